// File: rtl/param_bank_scheduler.sv
// rtl/param_bank_scheduler.sv - round-robin bank sequencer driving the parameter cache router sel/critical
// Processor ownership (critical) is always bracketed by a settle guard and a user access window.
module param_bank_scheduler #(
   parameter int GUARD_CYC = 2,
   parameter int WIN_CYC   = 4,
   parameter int HOLD_MAX  = 64,
   parameter int PASS_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [3:0]        bank_mask,
   input  logic              proc_done,
   input  logic              user_hold,
   output logic [1:0]        sel,
   output logic              critical,
   output logic              proc_start,
   output logic              user_win,
   output logic              busy,
   output logic [PASS_W-1:0] pass_count
);

   localparam int HOLD_EFF = (HOLD_MAX < WIN_CYC) ? WIN_CYC : HOLD_MAX;
   localparam int CNT_MAX  = (GUARD_CYC > HOLD_EFF) ? GUARD_CYC : HOLD_EFF;
   localparam int CNT_W    = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD_CYC);
   localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN_CYC);
   localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_EFF);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_GUARD,
      S_RUN,
      S_WINDOW
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              first, first_nx;
   logic [1:0]        sel_nx;
   logic              crit_nx, start_nx, win_nx;
   logic [PASS_W-1:0] pass_nx;

   logic [1:0] base, idx, pick;
   logic       found, wrap;

   // Next enabled bank above sel (or from bank 0 on the first pick); the current bank is the last candidate.
   always_comb begin
      base  = first ? 2'd0 : sel + 2'd1;
      pick  = sel;
      found = 1'b0;
      idx   = base;
      for (int i = 0; i < 4; i++) begin
         idx = base + 2'(i);
         if (!found && bank_mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      wrap = !first && (pick <= sel);
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      first_nx = first;
      sel_nx   = sel;
      crit_nx  = 1'b0;
      start_nx = 1'b0;
      win_nx   = 1'b0;
      pass_nx  = pass_count;
      case (state)
         S_IDLE: begin
            if (enable && (bank_mask != 4'b0000)) begin
               state_nx = S_SELECT;
               first_nx = 1'b1;
            end
         end
         S_SELECT: begin
            if (bank_mask == 4'b0000) begin
               state_nx = S_IDLE;
            end else begin
               sel_nx   = pick;
               first_nx = 1'b0;
               if (wrap)
                  pass_nx = pass_count + PASS_W'(1);
               if (GUARD_CYC == 0) begin
                  state_nx = S_RUN;
                  crit_nx  = 1'b1;
                  start_nx = 1'b1;
               end else begin
                  state_nx = S_GUARD;
                  cnt_nx   = CNT_ONE;
               end
            end
         end
         S_GUARD: begin
            if (cnt >= GUARD_C) begin
               state_nx = S_RUN;
               crit_nx  = 1'b1;
               start_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         S_RUN: begin
            crit_nx = 1'b1;
            if (proc_done) begin
               state_nx = S_WINDOW;
               crit_nx  = 1'b0;
               win_nx   = 1'b1;
               cnt_nx   = CNT_ONE;
            end
         end
         S_WINDOW: begin
            win_nx = 1'b1;
            if ((cnt >= WIN_C) && (!user_hold || (cnt >= HOLD_C))) begin
               win_nx   = 1'b0;
               state_nx = (enable && (bank_mask != 4'b0000)) ? S_SELECT : S_IDLE;
            end else if (cnt < HOLD_C) begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         first      <= 1'b0;
         sel        <= 2'd0;
         critical   <= 1'b0;
         proc_start <= 1'b0;
         user_win   <= 1'b0;
         busy       <= 1'b0;
         pass_count <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         first      <= first_nx;
         sel        <= sel_nx;
         critical   <= crit_nx;
         proc_start <= start_nx;
         user_win   <= win_nx;
         busy       <= (state_nx != S_IDLE);
         pass_count <= pass_nx;
      end
   end

endmodule
